// File: rtl/code_counter.sv
// code_counter: dual-channel event counter, channel 1 prescaled by DIV
module code_counter #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt0, r_cnt1;
  logic             w_wrap;
  assign w_wrap  = r_pre == PW'(DIV - 1);
  assign Output0 = r_cnt0;
  assign Output1 = r_cnt1;
  // prescaler only advances on Slt=1 and keeps its partial value otherwise
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_pre  <= '0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (En) begin
      if (Slt) begin
        r_pre <= w_wrap ? '0 : r_pre + 1'b1;
        if (w_wrap) r_cnt1 <= r_cnt1 + 1'b1;
      end else
        r_cnt0 <= r_cnt0 + 1'b1;
    end
endmodule

// File: tb/tb_code_counter.sv
// tb_code_counter: directed checks of code_counter, default, WIDTH=8 and DIV=1 instances
module tb_code_counter;
  logic        Clk = 0, Reset = 0;
  logic        Slt = 0, En = 0, Slt8 = 0, En8 = 0, Slt1 = 0, En1 = 0;
  logic [63:0] o0, o1;
  logic [7:0]  o0_8, o1_8;
  logic [63:0] o0_1, o1_1;
  int          n_cmp = 0, n_err = 0;

  always #10 Clk = ~Clk;

  code_counter dut (.Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Output0(o0), .Output1(o1));
  code_counter #(.WIDTH(8)) dut8 (.Clk(Clk), .Reset(Reset), .Slt(Slt8), .En(En8), .Output0(o0_8), .Output1(o1_8));
  code_counter #(.DIV(1)) dut1 (.Clk(Clk), .Reset(Reset), .Slt(Slt1), .En(En1), .Output0(o0_1), .Output1(o1_1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("rst_o0", o0, 0);
    chk("rst_o1", o1, 0);
    chk("rst_pre", 64'(dut.r_pre), 0);
    Reset = 1; En = 1; Slt = 1;
    step(3);
    chk("t1_before_div", o1, 0);
    step(1);
    chk("t1_first_inc", o1, 1);
    step(11);
    chk("t1_o1", o1, 3);
    chk("t1_pre", 64'(dut.r_pre), 3);
    chk("t1_o0", o0, 0);
    step(3);
    chk("t2_pre2", 64'(dut.r_pre), 2);
    chk("t2_o1_pre", o1, 4);
    Slt = 0;
    step(10);
    chk("t2_o0", o0, 10);
    chk("t2_o1_hold", o1, 4);
    chk("t2_pre_kept", 64'(dut.r_pre), 2);
    Slt = 1;
    step(1);
    chk("t2_edge1", o1, 4);
    step(1);
    chk("t2_edge2", o1, 5);
    step(1);
    En = 0;
    for (int i = 0; i < 8; i++) begin
      Slt = ~Slt;
      step(1);
    end
    chk("t3_o0", o0, 10);
    chk("t3_o1", o1, 5);
    chk("t3_pre", 64'(dut.r_pre), 1);
    En = 1; Slt = 0;
    step(27);
    chk("t4_o0_37", o0, 37);
    chk("t4_o1_5", o1, 5);
    #5 Reset = 0;
    #1;
    chk("t4_async_o0", o0, 0);
    chk("t4_async_o1", o1, 0);
    chk("t4_async_pre", 64'(dut.r_pre), 0);
    step(1);
    chk("t4_held_o0", o0, 0);
    Reset = 1;
    step(3);
    chk("t4_restart_o0", o0, 3);
    Slt = 1;
    step(3);
    chk("t4_restart_o1a", o1, 0);
    step(1);
    chk("t4_restart_o1b", o1, 1);
    En = 0;
    En8 = 1; Slt8 = 1;
    step(4);
    chk("t5_o1_8", 64'(o1_8), 1);
    Slt8 = 0;
    step(255);
    chk("t5_o0_255", 64'(o0_8), 255);
    step(1);
    chk("t5_wrap", 64'(o0_8), 0);
    chk("t5_o1_hold", 64'(o1_8), 1);
    En8 = 0;
    En1 = 1; Slt1 = 1;
    step(1);
    chk("t6_first", o1_1, 1);
    step(4);
    chk("t6_o1", o1_1, 5);
    chk("t6_o0", o0_1, 0);
    chk("t6_pre", 64'(dut1.r_pre), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
